// File: rtl/dis_score.sv
// BCD score counter with a scaled 5x7 glyph overlay; paint outputs are registered, one clock after paint_x/paint_y.
// Optional drop shadow when SCORE_SHADOW_EN is defined; otherwise only glyph pixels are drawn.
module dis_score #(
   parameter int          DIGITS   = 3,
   parameter int          SCALE    = 4,
   parameter logic [15:0] POS_X    = 16'd284,
   parameter logic [15:0] POS_Y    = 16'd40,
   parameter logic [15:0] FG_COLOR = 16'hFFFF
) (
   input  logic                  clk,
   input  logic                  rstn,
   input  logic                  score_inc,
   input  logic                  score_clr,
   input  logic                  new_frame,
   input  logic [15:0]           paint_x,
   input  logic [15:0]           paint_y,
   output logic [4*DIGITS-1:0]   score,
   output logic                  paint_enable,
   output logic [15:0]           paint_color
);

   localparam int P = 6 * SCALE;

   // Row 0 sits in the top 5 bits; bit 4 of each row is the leftmost column.
   localparam logic [34:0] FONT [0:15] = '{
      35'b01110_10001_10011_10101_11001_10001_01110,
      35'b00100_01100_00100_00100_00100_00100_01110,
      35'b01110_10001_00001_00010_00100_01000_11111,
      35'b11111_00010_00100_00010_00001_10001_01110,
      35'b00010_00110_01010_10010_11111_00010_00010,
      35'b11111_10000_11110_00001_00001_10001_01110,
      35'b00110_01000_10000_11110_10001_10001_01110,
      35'b11111_00001_00010_00100_01000_01000_01000,
      35'b01110_10001_10001_01110_10001_10001_01110,
      35'b01110_10001_10001_01111_00001_00010_01100,
      35'd0, 35'd0, 35'd0, 35'd0, 35'd0, 35'd0
   };

   logic [4*DIGITS-1:0] r_score;
   logic [4*DIGITS-1:0] r_disp;
   logic [4*DIGITS-1:0] w_score_nxt;
   logic                w_carry;
   logic                w_all9;
   logic                r_paint_en;
   logic [15:0]         r_paint_col;
   int                  w_rx;
   int                  w_ry;
   logic                w_glyph;
   logic                w_shadow;

   // Glyph test at field-relative coordinates; negative or out-of-field positions never hit.
   function automatic logic glyph_hit(input int rx, input int ry, input logic [4*DIGITS-1:0] d);
      int          di, col, row, k;
      logic [3:0]  v;
      logic [34:0] g;
      logic [4:0]  bits;
      logic [4:0]  sh;
      logic        blank;
      glyph_hit = 1'b0;
      if (rx >= 0 && rx < DIGITS * P && ry >= 0 && ry < 7 * SCALE) begin
         di    = rx / P;
         col   = (rx % P) / SCALE;
         row   = ry / SCALE;
         k     = DIGITS - 1 - di;
         v     = 4'(d >> (4 * k));
         blank = (k > 0) && ((d >> (4 * k)) == '0);
         g     = FONT[v];
         bits  = 5'(g >> (5 * (6 - row)));
         sh    = 5'(bits << col);
         if (col < 5 && !blank)
            glyph_hit = sh[4];
      end
   endfunction

   always_comb begin
      w_score_nxt = r_score;
      w_carry     = 1'b1;
      w_all9      = 1'b1;
      for (int i = 0; i < DIGITS; i++) begin
         if (r_score[4*i +: 4] != 4'd9)
            w_all9 = 1'b0;
         if (w_carry) begin
            if (r_score[4*i +: 4] == 4'd9) begin
               w_score_nxt[4*i +: 4] = 4'd0;
            end else begin
               w_score_nxt[4*i +: 4] = r_score[4*i +: 4] + 4'd1;
               w_carry               = 1'b0;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_score <= '0;
         r_disp  <= '0;
      end else begin
         if (score_clr)
            r_score <= '0;
         else if (score_inc && !w_all9)
            r_score <= w_score_nxt;
         // Latches the pre-update score, so an increment in the same cycle shows next frame.
         if (new_frame)
            r_disp <= r_score;
      end
   end

   assign w_rx    = int'(paint_x) - int'(POS_X);
   assign w_ry    = int'(paint_y) - int'(POS_Y);
   assign w_glyph = glyph_hit(w_rx, w_ry, r_disp);

`ifdef SCORE_SHADOW_EN
   assign w_shadow = ~w_glyph & glyph_hit(w_rx - SCALE, w_ry - SCALE, r_disp);
`else
   assign w_shadow = 1'b0;
`endif

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_paint_en  <= 1'b0;
         r_paint_col <= 16'h0000;
      end else begin
         r_paint_en  <= w_glyph | w_shadow;
         r_paint_col <= w_glyph ? FG_COLOR : 16'h0000;
      end
   end

   assign score        = r_score;
   assign paint_enable = r_paint_en;
   assign paint_color  = r_paint_col;

endmodule

// File: tb/tb_dis_score.sv
// Directed bench for dis_score at default parameters (3 digits, scale 4, field origin 284,40).
module tb_dis_score;
   localparam int X0 = 284;
   localparam int Y0 = 40;

   logic        clk = 1'b0;
   logic        rstn = 1'b0;
   logic        score_inc = 1'b0;
   logic        score_clr = 1'b0;
   logic        new_frame = 1'b0;
   logic [15:0] paint_x = 16'd0;
   logic [15:0] paint_y = 16'd0;
   logic [11:0] score;
   logic        paint_enable;
   logic [15:0] paint_color;

   int vectors = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   dis_score dut (
      .clk          (clk),
      .rstn         (rstn),
      .score_inc    (score_inc),
      .score_clr    (score_clr),
      .new_frame    (new_frame),
      .paint_x      (paint_x),
      .paint_y      (paint_y),
      .score        (score),
      .paint_enable (paint_enable),
      .paint_color  (paint_color)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic pix(input string tag, input int rx, input int ry,
                      input logic en_exp, input logic [15:0] col_exp);
      @(negedge clk);
      paint_x = 16'(X0 + rx);
      paint_y = 16'(Y0 + ry);
      @(posedge clk);
      #1;
      chk({tag, ".en"}, {31'd0, paint_enable}, {31'd0, en_exp});
      chk({tag, ".col"}, {16'd0, paint_color}, {16'd0, col_exp});
   endtask

   task automatic incs(input int n);
      @(negedge clk);
      score_inc = 1'b1;
      repeat (n) @(negedge clk);
      score_inc = 1'b0;
   endtask

   task automatic frame();
      @(negedge clk);
      new_frame = 1'b1;
      @(negedge clk);
      new_frame = 1'b0;
   endtask

   task automatic clr();
      @(negedge clk);
      score_clr = 1'b1;
      @(negedge clk);
      score_clr = 1'b0;
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1;
      chk("rst.score", {20'd0, score}, 32'h0);
      chk("rst.en", {31'd0, paint_enable}, 32'd0);
      chk("rst.col", {16'd0, paint_color}, 32'd0);
      @(negedge clk);
      rstn = 1'b1;

      // disp = 0 after reset: units digit shows "0", higher digits suppressed
      pix("zero.u_c1r0", 52, 0, 1'b1, 16'hFFFF);
      pix("zero.u_c0r0", 48, 0, 1'b0, 16'h0000);
      pix("zero.u_gap", 68, 0, 1'b0, 16'h0000);
      pix("zero.h_gap", 20, 0, 1'b0, 16'h0000);
      pix("zero.t_lz", 32, 0, 1'b0, 16'h0000);

      // exactly one clock from coordinate to paint output
      @(negedge clk);
      paint_x = 16'(X0 + 52);
      paint_y = 16'(Y0);
      #1;
      chk("lat.before_edge", {31'd0, paint_enable}, 32'd0);
      @(posedge clk);
      #1;
      chk("lat.after_edge", {31'd0, paint_enable}, 32'd1);

      incs(12);
      chk("inc12.score", {20'd0, score}, 32'h012);
      pix("inc12.no_frame_yet", 32, 0, 1'b0, 16'h0000);
      frame();
      pix("s12.t_c2r0", 32, 0, 1'b1, 16'hFFFF);
      pix("s12.t_c0r0", 24, 0, 1'b0, 16'h0000);
      pix("s12.t_scaled", 35, 0, 1'b1, 16'hFFFF);
      pix("s12.u_c1r0", 52, 0, 1'b1, 16'hFFFF);
      pix("s12.u_c0r0", 48, 0, 1'b0, 16'h0000);
      pix("s12.u_c0r6", 48, 24, 1'b1, 16'hFFFF);
      pix("s12.u_c0r6b", 48, 27, 1'b1, 16'hFFFF);
      pix("s12.below", 48, 28, 1'b0, 16'h0000);
      pix("s12.h_lz_r0", 8, 0, 1'b0, 16'h0000);
      pix("s12.h_lz_r3", 8, 12, 1'b0, 16'h0000);
      pix("s12.above", 32, -1, 1'b0, 16'h0000);
      pix("s12.left", -1, 0, 1'b0, 16'h0000);
      pix("s12.origin0", -X0, -Y0, 1'b0, 16'h0000);
`ifdef SCORE_SHADOW_EN
      pix("s12.shadow", 36, 4, 1'b1, 16'h0000);
`else
      pix("s12.shadow", 36, 4, 1'b0, 16'h0000);
`endif

      clr();
      chk("clr.score", {20'd0, score}, 32'h0);
      incs(99);
      chk("sat.099", {20'd0, score}, 32'h099);
      incs(1);
      chk("sat.100", {20'd0, score}, 32'h100);
      incs(899);
      chk("sat.999", {20'd0, score}, 32'h999);
      incs(3);
      chk("sat.hold", {20'd0, score}, 32'h999);

      clr();
      incs(5);
      chk("cx.5", {20'd0, score}, 32'h005);
      @(negedge clk);
      score_inc = 1'b1;
      score_clr = 1'b1;
      @(negedge clk);
      score_inc = 1'b0;
      score_clr = 1'b0;
      chk("cx.clr_wins", {20'd0, score}, 32'h0);

      incs(7);
      @(negedge clk);
      score_inc = 1'b1;
      new_frame = 1'b1;
      @(negedge clk);
      score_inc = 1'b0;
      new_frame = 1'b0;
      chk("nf.score8", {20'd0, score}, 32'h008);
      pix("nf.shows7", 48, 0, 1'b1, 16'hFFFF);
      pix("nf.t_lz", 32, 0, 1'b0, 16'h0000);
      frame();
      pix("nf.shows8", 48, 0, 1'b0, 16'h0000);

      incs(3);
      frame();
      pix("mr.shows11", 32, 0, 1'b1, 16'hFFFF);
      #2;
      rstn = 1'b0;
      #1;
      chk("mr.en", {31'd0, paint_enable}, 32'd0);
      chk("mr.col", {16'd0, paint_color}, 32'd0);
      chk("mr.score", {20'd0, score}, 32'h0);
      @(negedge clk);
      rstn = 1'b1;
      pix("mr.u_zero", 52, 0, 1'b1, 16'hFFFF);
      pix("mr.t_blank", 32, 0, 1'b0, 16'h0000);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
